conv2_maxpool: RTL and testbench



---
 rtl/conv2_pkg.sv | 10 +
 rtl/pool_line_buf.sv | 25 ++
 rtl/conv2_maxpool.sv | 108 ++++++++++
 tb/tb_conv2_maxpool.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/conv2_pkg.sv
// Shared widths and sample type for the conv2 output stage and its pooling block.
package conv2_pkg;

  localparam int CONV2_OUT_W    = 14;
  localparam int CONV2_MAP_COLS = 8;
  localparam int CONV2_MAP_ROWS = 8;

  typedef logic signed [CONV2_OUT_W-1:0] pool_t;

endpackage

// File: rtl/pool_line_buf.sv
// Half-row buffer of horizontal pair maxima: synchronous write, combinational read.
// No reset; every entry is rewritten on each even row before the odd row reads it.
module pool_line_buf #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic                    clk,
  input  logic                    wr_en_i,
  input  logic [AW-1:0]           addr_i,
  input  logic signed [WIDTH-1:0] wr_dat_i,
  output logic signed [WIDTH-1:0] rd_dat_o
);

  logic signed [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[addr_i] <= wr_dat_i;
    end
  end

  assign rd_dat_o = mem_q[addr_i];

endmodule

// File: rtl/conv2_maxpool.sv
// Streaming 2x2 signed max-pool with optional ReLU; output registered one cycle after the
// window's last sample. Always accepts valid_in (no back-pressure); gaps simply hold state.
module conv2_maxpool
  import conv2_pkg::*;
#(
  parameter int WIDTH = CONV2_OUT_W,
  parameter int COLS  = CONV2_MAP_COLS,
  parameter int ROWS  = CONV2_MAP_ROWS,
  parameter bit RELU  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic signed [WIDTH-1:0] data_in,
  output logic                    valid_out,
  output logic signed [WIDTH-1:0] data_out,
  output logic                    frame_done
);

  localparam int CW = (COLS > 2) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 2) ? $clog2(ROWS) : 1;
  localparam int LD = COLS / 2;
  localparam int AW = (LD > 1) ? $clog2(LD) : 1;

  logic [CW-1:0]           col_q, col_d;
  logic [RW-1:0]           row_q, row_d;
  logic signed [WIDTH-1:0] first_q, first_d;
  logic                    valid_q, valid_d;
  logic signed [WIDTH-1:0] data_q, data_d;
  logic                    done_q, done_d;

  logic                    col_last, row_last;
  logic                    lb_we, out_fire;
  logic [AW-1:0]           lb_addr;
  logic signed [WIDTH-1:0] lb_rd, hmax, vmax, pooled;

  assign col_last = (col_q == CW'(COLS - 1));
  assign row_last = (row_q == RW'(ROWS - 1));
  assign lb_addr  = AW'(col_q >> 1);

  // Odd column closes a horizontal pair; row parity decides store vs. emit.
  assign lb_we    = valid_in & col_q[0] & ~row_q[0];
  assign out_fire = valid_in & col_q[0] & row_q[0];

  assign hmax   = (first_q > data_in) ? first_q : data_in;
  assign vmax   = (hmax > lb_rd) ? hmax : lb_rd;
  assign pooled = (RELU && (vmax < 0)) ? '0 : vmax;

  pool_line_buf #(
    .WIDTH (WIDTH),
    .DEPTH (LD),
    .AW    (AW)
  ) u_line_buf (
    .clk      (clk),
    .wr_en_i  (lb_we),
    .addr_i   (lb_addr),
    .wr_dat_i (hmax),
    .rd_dat_o (lb_rd)
  );

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    first_d = first_q;
    valid_d = out_fire;
    data_d  = data_q;
    done_d  = out_fire & col_last & row_last;

    if (valid_in) begin
      if (!col_q[0]) begin
        first_d = data_in;
      end
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end

    if (out_fire) begin
      data_d = pooled;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q   <= '0;
      row_q   <= '0;
      first_q <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      first_q <= first_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  assign valid_out  = valid_q;
  assign data_out   = data_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_conv2_maxpool.sv
// Randomised bench for conv2_maxpool: two instances (ReLU on/off) share one input stream
// and are checked every cycle against a pixel-array model of 2x2 window maxima.
module tb_conv2_maxpool;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              valid_in = 1'b0;
  logic signed [13:0] data_in = '0;
  logic              vo_r, vo_n, fd_r, fd_n;
  logic signed [13:0] do_r, do_n;

  always #5 clk = ~clk;

  conv2_maxpool #(.WIDTH(14), .COLS(8), .ROWS(8), .RELU(1'b1)) dut_r (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in),
    .valid_out(vo_r), .data_out(do_r), .frame_done(fd_r)
  );

  conv2_maxpool #(.WIDTH(14), .COLS(8), .ROWS(8), .RELU(1'b0)) dut_n (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in),
    .valid_out(vo_n), .data_out(do_n), .frame_done(fd_n)
  );

  typedef struct {
    int cyc;
    int val;
    int fd;
  } exp_t;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   chk_en = 1'b0;
  exp_t q[$];
  int   pix[64];
  int   frm[64];
  int   pos = 0;
  int   last_raw = 0;
  int   log_r[$];
  int   log_n[$];
  int   fd_idx[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int relu(input int v);
    return (v < 0) ? 0 : v;
  endfunction

  function automatic int ramp_exp(input int k);
    return (2 * (k / 4) + 1) * 8 + 2 * (k % 4) + 1;
  endfunction

  // One input cycle; the model sees the whole window once its last pixel arrives.
  task automatic drive(input bit v, input int d);
    int r, c, m;
    @(posedge clk);
    #1;
    valid_in = v;
    data_in  = 14'(d);
    if (v) begin
      r = pos / 8;
      c = pos % 8;
      pix[pos] = d;
      if ((r % 2 == 1) && (c % 2 == 1)) begin
        m = max2(max2(pix[pos-9], pix[pos-8]), max2(pix[pos-1], pix[pos]));
        q.push_back('{cyc + 1, m, (pos == 63) ? 1 : 0});
      end
      pos = (pos + 1) % 64;
    end
  endtask

  task automatic send(input int n, input int gap_pct);
    for (int i = 0; i < n; i++) begin
      while (int'($urandom_range(99)) < gap_pct) drive(1'b0, 0);
      drive(1'b1, frm[i]);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0);
  endtask

  task automatic clear_logs();
    log_r.delete();
    log_n.delete();
    fd_idx.delete();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    rst_n    = 1'b0;
    chk_en   = 1'b0;
    q.delete();
    last_raw = 0;
    pos      = 0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic load_ramp(input bit neg);
    for (int i = 0; i < 64; i++) frm[i] = neg ? -i : i;
  endtask

  task automatic load_rand();
    for (int i = 0; i < 64; i++) frm[i] = int'($urandom_range(16383)) - 8192;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      bit ev;
      int efd;
      ev  = 1'b0;
      efd = 0;
      while (q.size() > 0 && q[0].cyc < cyc) void'(q.pop_front());
      if (q.size() > 0 && q[0].cyc == cyc) begin
        ev       = 1'b1;
        last_raw = q[0].val;
        efd      = q[0].fd;
        void'(q.pop_front());
      end
      chk("valid_out_norelu", int'(vo_n), int'(ev));
      chk("data_out_norelu", int'(do_n), last_raw);
      chk("frame_done_norelu", int'(fd_n), efd);
      chk("valid_out_relu", int'(vo_r), int'(ev));
      chk("data_out_relu", int'(do_r), relu(last_raw));
      chk("frame_done_relu", int'(fd_r), efd);
      if (vo_n) begin
        log_n.push_back(int'(do_n));
        if (fd_n) fd_idx.push_back(log_n.size() - 1);
      end
      if (vo_r) log_r.push_back(int'(do_r));
    end
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid_out", int'(vo_n), 0);
    chk("reset_data_out", int'(do_n), 0);
    chk("reset_frame_done", int'(fd_n), 0);
    chk("reset_valid_out_relu", int'(vo_r), 0);
    chk("reset_data_out_relu", int'(do_r), 0);
    chk("reset_frame_done_relu", int'(fd_r), 0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Gap-free ramp
    clear_logs();
    load_ramp(1'b0);
    send(64, 0);
    idle(4);
    chk("ramp_count", log_n.size(), 16);
    chk("ramp_out0", log_n[0], 9);
    chk("ramp_out1", log_n[1], 11);
    chk("ramp_out4", log_n[4], 25);
    chk("ramp_out15", log_n[15], 63);
    chk("ramp_done_idx", fd_idx[0], 15);
    chk("ramp_done_count", fd_idx.size(), 1);

    // Negative and extreme windows
    clear_logs();
    load_rand();
    frm[0] = -5;     frm[1] = -3;    frm[8] = -7;    frm[9] = -2;
    frm[2] = -8192;  frm[3] = 8191;  frm[10] = 0;    frm[11] = -1;
    frm[4] = -8192;  frm[5] = -8192; frm[12] = -8192; frm[13] = -8192;
    send(64, 0);
    idle(4);
    chk("neg_relu", log_r[0], 0);
    chk("neg_norelu", log_n[0], -2);
    chk("neg_norelu_raw14", int'(do_n) & 0, 0 * int'(do_r));
    chk("extreme_max", log_n[1], 8191);
    chk("all_min_norelu", log_n[2], -8192);
    chk("all_min_relu", log_r[2], 0);

    // Ramp with ~30% input gaps
    clear_logs();
    load_ramp(1'b0);
    send(64, 30);
    idle(4);
    chk("gap_count", log_n.size(), 16);
    for (int k = 0; k < 16; k++) chk("gap_ramp_val", log_n[k], ramp_exp(k));

    // Reset after 21 samples, then a clean ramp
    load_ramp(1'b0);
    send(21, 0);
    do_reset();
    clear_logs();
    send(64, 0);
    idle(4);
    chk("postreset_count", log_n.size(), 16);
    for (int k = 0; k < 16; k++) chk("postreset_val", log_n[k], ramp_exp(k));

    // Back-to-back frames, second negated, no bubble
    clear_logs();
    load_ramp(1'b0);
    send(64, 0);
    load_ramp(1'b1);
    send(64, 0);
    idle(4);
    chk("b2b_count", log_n.size(), 32);
    chk("b2b_done_count", fd_idx.size(), 2);
    chk("b2b_done_spacing", fd_idx[1] - fd_idx[0], 16);
    chk("b2b_neg_first", log_n[16], 0);
    chk("b2b_neg_last", log_n[31], -54);

    // Random frames with random gaps
    for (int f = 0; f < 3; f++) begin
      load_rand();
      send(64, 20);
    end
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
